uart_to_parallel_rx: RTL and testbench
======================================

Name: uart_to_parallel_rx

Overview:
- UART receiver: the inbound counterpart to the team's parallel-to-UART transmitter. Frame format is 8N1, LSB first.
- Deserialises a byte from a single rx line into a holding register.
- Host reads the byte as two 4-bit nibbles through a select pin, matching the 4-pin parallel data bus used on the transmit side.
- Sits between the chip's rx input pin and the narrow parallel output bus.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit. Must be >= 4. HALF = CLKS_PER_BIT/2, rounded down.
- SYNC_STAGES, 2: flops in the rx metastability synchroniser. Must be >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial input; idles high
- nibble_sel  input  1  0 selects hold[3:0] onto data_out, 1 selects hold[7:4]
- ack  input  1  one-cycle pulse; clears data_valid and overrun
- data_out  output  4  selected nibble of the holding register
- data_valid  output  1  a new byte is held and not yet acknowledged
- frame_err  output  1  sticky; last frame had stop bit = 0
- overrun  output  1  sticky; a byte completed while data_valid was already 1
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: clk and reset already decided (reset synchronous, active-high; clock clk).
  - Synchroniser flops preset to 1; state = IDLE; counters = 0; hold = 8'h00.
  - data_valid = 0, frame_err = 0, overrun = 0, busy = 0, so data_out = 4'h0.
  - Reset asserted mid-frame aborts the frame immediately; the partial byte is discarded.
- rx_s is the output of the SYNC_STAGES-deep synchroniser. All decisions use rx_s only.
- data_out is combinational from hold and nibble_sel (zero latency). Every other output is registered.
- State machine states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s = 0 (call this cycle t0), clear the cycle counter and go to START.
  - START: at t0+HALF, sample rx_s.
    - If 1: treat as a glitch and return to IDLE; no flags change.
    - If 0: go to DATA with bit index = 0 and the cycle counter cleared.
  - DATA: sample bit i at t0 + HALF + (i+1)*CLKS_PER_BIT and shift it into the shift register LSB first. After bit 7, go to STOP.
  - STOP: sample at t0 + HALF + 9*CLKS_PER_BIT.
    - Stop = 1: on the next clk, hold <= shift register, data_valid <= 1, frame_err <= 0; state goes to IDLE.
    - Stop = 0: frame_err <= 1; hold and data_valid are unchanged; state goes to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- Overrun: a good frame completing while data_valid = 1 and ack = 0 sets overrun <= 1. The hold register is overwritten with the new byte.
- ack:
  - Clears data_valid and overrun on the next clk.
  - Does not clear frame_err; frame_err clears only on reset or on the next good frame.
- Simultaneous ack and good-frame completion in the same cycle: data_valid stays 1, hold takes the new byte, overrun is not set.
- ack while data_valid = 0 has no effect.
- Back-to-back frames: IDLE accepts a new start bit in the cycle after the STOP sample, so there is no required inter-frame gap.
- Counter widths: cycle counter is clog2(CLKS_PER_BIT) bits; bit index is 3 bits. Neither may wrap inside a bit period.

Test Plan (CLKS_PER_BIT = 16, SYNC_STAGES = 2):
1. Reset, then send 0xA5 with a valid stop bit. Required: data_valid rises exactly one cycle after the stop-bit sample; nibble_sel = 0 gives data_out = 4'h5, nibble_sel = 1 gives 4'hA; frame_err = 0, overrun = 0; ack clears data_valid the next cycle.
2. Drive rx low for 4 cycles only, then high. Required: busy pulses while in START, then returns to IDLE; data_valid, frame_err and hold are unchanged.
3. Send 0x3C with stop bit = 0, hold rx low 40 cycles, release, then send 0x81 correctly. Required: frame_err = 1 and hold still shows the previous byte after the first frame; state stays in WAIT_HIGH until rx returns high; after 0x81, data = 8'h81, data_valid = 1, frame_err = 0.
4. Send 0x11 then 0x22 back-to-back with no ack. Required: overrun = 1 and data_out = 2/2 for both nibble selects; a single ack clears both data_valid and overrun.
5. Assert ack in exactly the cycle the second byte completes. Required: data_valid stays 1, overrun = 0, hold = the second byte.
6. Assert reset during bit 4 of a frame. Required: all outputs return to reset values the next cycle; a full 0x5A frame sent immediately after reset deassertion is received correctly.

Source files
------------

// File: rtl/uart_to_parallel_rx.sv
// UART 8N1 receiver with a nibble-wide host read port.
// The rx pin is synchronised, each bit is sampled mid-period, and the completed
// byte lands in a holding register that the host reads as two 4-bit nibbles.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | counting to mid start bit; a high sample there is a glitch
// DATA      | sampling eight data bits, LSB first
// STOP      | sampling the stop bit; good frame updates hold/data_valid
// WAIT_HIGH | bad stop bit seen; wait for line to go high before re-arming
module uart_to_parallel_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       nibble_sel,
   input  logic       ack,
   output logic [3:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);

   // Terminal counts: the counter starts at 0 on the edge that enters a
   // phase, so reaching N-1 marks the N-th edge of that phase.
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s;
   logic [CW-1:0]          cnt;
   logic [2:0]             bit_idx;
   logic [7:0]             shift;
   logic [7:0]             hold;

   // Metastability synchroniser; presets high so reset looks like an idle line.
   always_ff @(posedge clk) begin
      if (reset) sync <= '1;
      else       sync <= {sync[SYNC_STAGES-2:0], rx};
   end

   assign rx_s = sync[SYNC_STAGES-1];

   assign data_out = nibble_sel ? hold[7:4] : hold[3:0];

   // Receive FSM with all status outputs registered alongside it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= 8'h00;
         hold       <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // Host acknowledge; a good frame completing this same cycle overrides it below.
         if (ack) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  cnt   <= '0;
                  state <= START;
                  busy  <= 1'b1;
               end
            end

            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shift <= {rx_s, shift[7:1]};
                  if (bit_idx == 3'd7) state <= STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     hold       <= shift;
                     data_valid <= 1'b1;
                     frame_err  <= 1'b0;
                     // An ack landing with the new byte consumes the old one cleanly.
                     overrun    <= !ack && (overrun || data_valid);
                     state      <= IDLE;
                     busy       <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            WAIT_HIGH: begin
               if (rx_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_to_parallel_rx.sv
// Directed bench for uart_to_parallel_rx at CLKS_PER_BIT = 16, SYNC_STAGES = 2.
// Timing reference: rx is driven 1 ns after an edge e0; it reaches rx_s after
// two edges, IDLE reacts at e0+3 (t0), the stop sample lands at
// t0 + 8 + 9*16 = e0+155, so data_valid is visible after edge e0+155.
module tb_uart_to_parallel_rx;

   logic       clk;
   logic       reset;
   logic       rx;
   logic       nibble_sel;
   logic       ack;
   logic [3:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   uart_to_parallel_rx #(
      .CLKS_PER_BIT (16),
      .SYNC_STAGES  (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .nibble_sel (nibble_sel),
      .ack        (ack),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reads both nibbles of the holding register through data_out.
   task automatic check_hold(input string tag, input logic [7:0] exp);
      logic [7:0] got;
      nibble_sel = 1'b0;
      #1;
      got[3:0] = data_out;
      nibble_sel = 1'b1;
      #1;
      got[7:4] = data_out;
      nibble_sel = 1'b0;
      check(tag, got, exp);
   endtask

   // One 8N1 frame, 16 clocks per bit; rx is left at the stop level.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         repeat (16) tick();
      end
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      rx         = 1'b1;
      nibble_sel = 1'b0;
      ack        = 1'b0;
      repeat (3) tick();

      check("rst_dv",   {7'd0, data_valid}, 8'd0);
      check("rst_fe",   {7'd0, frame_err},  8'd0);
      check("rst_ov",   {7'd0, overrun},    8'd0);
      check("rst_busy", {7'd0, busy},       8'd0);
      check_hold("rst_hold", 8'h00);
      reset = 1'b0;
      repeat (2) tick();

      // 1: 0xA5, data_valid rises exactly after the stop-sample edge
      fork
         send_frame(8'hA5, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1;
            check("t1_dv_before", {7'd0, data_valid}, 8'd0);
            @(posedge clk);
            #1;
            check("t1_dv_at", {7'd0, data_valid}, 8'd1);
         end
      join
      check_hold("t1_hold", 8'hA5);
      check("t1_fe", {7'd0, frame_err}, 8'd0);
      check("t1_ov", {7'd0, overrun},   8'd0);
      ack_pulse();
      check("t1_ack_dv", {7'd0, data_valid}, 8'd0);

      // 2: 4-cycle glitch
      rx = 1'b0;
      repeat (4) tick();
      check("t2_busy_start", {7'd0, busy}, 8'd1);
      rx = 1'b1;
      repeat (8) tick();
      check("t2_busy_idle", {7'd0, busy},       8'd0);
      check("t2_dv",        {7'd0, data_valid}, 8'd0);
      check("t2_fe",        {7'd0, frame_err},  8'd0);
      check_hold("t2_hold", 8'hA5);

      // 3: bad stop bit, break held low, then a good frame
      send_frame(8'h3C, 1'b0);
      check("t3_fe",   {7'd0, frame_err},  8'd1);
      check("t3_busy", {7'd0, busy},       8'd1);
      check("t3_dv",   {7'd0, data_valid}, 8'd0);
      check_hold("t3_hold_kept", 8'hA5);
      repeat (40) tick();
      check("t3_wait_high", {7'd0, busy}, 8'd1);
      rx = 1'b1;
      repeat (4) tick();
      check("t3_released", {7'd0, busy}, 8'd0);
      send_frame(8'h81, 1'b1);
      check("t3_dv81", {7'd0, data_valid}, 8'd1);
      check("t3_fe81", {7'd0, frame_err},  8'd0);
      check_hold("t3_hold81", 8'h81);
      ack_pulse();

      // 4: back-to-back without ack -> overrun
      send_frame(8'h11, 1'b1);
      check("t4_dv11", {7'd0, data_valid}, 8'd1);
      check("t4_ov11", {7'd0, overrun},    8'd0);
      check_hold("t4_hold11", 8'h11);
      send_frame(8'h22, 1'b1);
      check("t4_ov22", {7'd0, overrun},    8'd1);
      check("t4_dv22", {7'd0, data_valid}, 8'd1);
      check_hold("t4_hold22", 8'h22);
      ack_pulse();
      check("t4_ack_dv", {7'd0, data_valid}, 8'd0);
      check("t4_ack_ov", {7'd0, overrun},    8'd0);

      // 5: ack coincident with completion of the second byte
      send_frame(8'h33, 1'b1);
      check("t5_dv33", {7'd0, data_valid}, 8'd1);
      fork
         send_frame(8'h44, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1;
            ack = 1'b1;
            @(posedge clk);
            #1;
            ack = 1'b0;
         end
      join
      check("t5_dv", {7'd0, data_valid}, 8'd1);
      check("t5_ov", {7'd0, overrun},    8'd0);
      check_hold("t5_hold", 8'h44);

      // bad frame so reset has a sticky frame_err to clear
      send_frame(8'h00, 1'b0);
      rx = 1'b1;
      repeat (4) tick();
      check("t6_pre_fe", {7'd0, frame_err},  8'd1);
      check("t6_pre_dv", {7'd0, data_valid}, 8'd1);

      // 6: reset during bit 4 of a frame, then a clean 0x5A
      rx = 1'b0;
      repeat (16) tick();
      rx = 1'b1;
      repeat (69) tick();
      check("t6_busy_mid", {7'd0, busy}, 8'd1);
      reset = 1'b1;
      tick();
      check("t6_rst_dv",   {7'd0, data_valid}, 8'd0);
      check("t6_rst_fe",   {7'd0, frame_err},  8'd0);
      check("t6_rst_ov",   {7'd0, overrun},    8'd0);
      check("t6_rst_busy", {7'd0, busy},       8'd0);
      check_hold("t6_rst_hold", 8'h00);
      reset = 1'b0;
      send_frame(8'h5A, 1'b1);
      check("t6_dv", {7'd0, data_valid}, 8'd1);
      check("t6_fe", {7'd0, frame_err},  8'd0);
      check("t6_ov", {7'd0, overrun},    8'd0);
      check_hold("t6_hold", 8'h5A);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
